// File: rtl/div_ratio_ctrl.sv
// Glitch-safe ratio update controller for a downstream clock divider: holds the
// divider disabled, swaps the ratio, re-enables. Optional ratio-0 rejection under RATIO_CHECK_EN.
module div_ratio_ctrl #(
  parameter int         QUIET_CYCLES = 4,
  parameter logic [7:0] RESET_RATIO  = 8'd1
) (
  input  logic       I_ref_clk,
  input  logic       I_rst_n,
  input  logic       I_en,
  input  logic       I_req_valid,
  input  logic [7:0] I_req_ratio,
  output logic       O_req_ready,
  output logic [7:0] O_div_ratio,
  output logic       O_clk_en,
  output logic       O_upd_done,
  output logic       O_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    QUIESCE = 2'd1,
    LOAD    = 2'd2,
    RESUME  = 2'd3
  } state_t;

  localparam logic [3:0] QC_LAST = 4'(QUIET_CYCLES - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] pending_q, pending_d;
  logic [7:0] ratio_q, ratio_d;
  logic       gate_q, gate_d;
  logic       upd_q, upd_d;

  logic accept;
  logic same_ratio;
  logic reject;

  assign accept     = I_req_valid && (state_q == IDLE);
  assign same_ratio = (I_req_ratio == ratio_q);

`ifdef RATIO_CHECK_EN
  logic err_q, err_d;
  assign reject = (I_req_ratio == 8'd0);
`else
  assign reject = 1'b0;
`endif

  // State register
  always_ff @(posedge I_ref_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept && !reject && !same_ratio) begin
          state_d = I_en ? QUIESCE : LOAD;
        end
      end
      QUIESCE: begin
        if (cnt_q == QC_LAST) begin
          state_d = LOAD;
        end
      end
      LOAD:    state_d = RESUME;
      RESUME:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next values; gate and done are derived from the next
  // state so they line up with the state they describe.
  always_comb begin
    cnt_d     = 4'd0;
    pending_d = pending_q;
    ratio_d   = ratio_q;
    gate_d    = 1'b1;
    upd_d     = 1'b0;

    if (state_q == QUIESCE) begin
      cnt_d = cnt_q + 4'd1;
    end
    if (accept && !reject) begin
      pending_d = I_req_ratio;
    end
    if (state_q == LOAD) begin
      ratio_d = pending_q;
    end
    gate_d = (state_d == IDLE) || (state_d == RESUME);
    upd_d  = (state_d == RESUME) || (accept && !reject && same_ratio);
  end

`ifdef RATIO_CHECK_EN
  always_comb begin
    err_d = accept && reject;
  end
`endif

  always_ff @(posedge I_ref_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      cnt_q     <= 4'd0;
      pending_q <= RESET_RATIO;
      ratio_q   <= RESET_RATIO;
      gate_q    <= 1'b1;
      upd_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      ratio_q   <= ratio_d;
      gate_q    <= gate_d;
      upd_q     <= upd_d;
    end
  end

`ifdef RATIO_CHECK_EN
  always_ff @(posedge I_ref_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
  assign O_err = err_q;
`else
  assign O_err = 1'b0;
`endif

  assign O_req_ready = (state_q == IDLE);
  assign O_div_ratio = ratio_q;
  assign O_clk_en    = I_en && gate_q;
  assign O_upd_done  = upd_q;

  // The ratio may only move while the divider is gated off.
  a_ratio_only_in_load: assert property (
    @(posedge I_ref_clk) disable iff (!I_rst_n)
    (ratio_d != ratio_q) |-> (state_q == LOAD && !gate_q)
  );

endmodule

// File: tb/tb_div_ratio_ctrl.sv
// Directed bench for div_ratio_ctrl: cycle table plus reset and ratio-0 sequences.
module tb_div_ratio_ctrl;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       req_valid;
  logic [7:0] req_ratio;
  logic       req_ready;
  logic [7:0] div_ratio;
  logic       clk_en;
  logic       upd_done;
  logic       err;

  int total = 0;
  int bad   = 0;

  div_ratio_ctrl #(.QUIET_CYCLES(4), .RESET_RATIO(8'd1)) dut (
    .I_ref_clk   (clk),
    .I_rst_n     (rst_n),
    .I_en        (en),
    .I_req_valid (req_valid),
    .I_req_ratio (req_ratio),
    .O_req_ready (req_ready),
    .O_div_ratio (div_ratio),
    .O_clk_en    (clk_en),
    .O_upd_done  (upd_done),
    .O_err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       valid;
    logic [7:0] ratio;
    logic       e_ready;
    logic [7:0] e_ratio;
    logic       e_clk;
    logic       e_upd;
    logic       e_err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic e_ready, input logic [7:0] e_ratio,
                         input logic e_clk, input logic e_upd, input logic e_err);
    chk({tag, ".ready"}, {7'd0, req_ready}, {7'd0, e_ready});
    chk({tag, ".ratio"}, div_ratio, e_ratio);
    chk({tag, ".clk_en"}, {7'd0, clk_en}, {7'd0, e_clk});
    chk({tag, ".upd"}, {7'd0, upd_done}, {7'd0, e_upd});
    chk({tag, ".err"}, {7'd0, err}, {7'd0, e_err});
  endtask

  task automatic step(input logic e, input logic v, input logic [7:0] r);
    @(negedge clk);
    en = e; req_valid = v; req_ratio = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // en valid ratio | ready ratio clk_en upd err (after the edge)
    vecs.push_back('{1, 0, 8'd0, 1, 8'd1, 1, 0, 0});  // idle
    vecs.push_back('{1, 1, 8'd6, 0, 8'd1, 0, 0, 0});  // accept 6, Q1
    vecs.push_back('{1, 1, 8'd3, 0, 8'd1, 0, 0, 0});  // Q2, held off
    vecs.push_back('{0, 1, 8'd3, 0, 8'd1, 0, 0, 0});  // Q3, en toggled
    vecs.push_back('{1, 1, 8'd3, 0, 8'd1, 0, 0, 0});  // Q4
    vecs.push_back('{1, 1, 8'd3, 0, 8'd1, 0, 0, 0});  // LOAD
    vecs.push_back('{1, 1, 8'd3, 0, 8'd6, 1, 1, 0});  // RESUME
    vecs.push_back('{1, 1, 8'd3, 1, 8'd6, 1, 0, 0});  // IDLE, not yet accepted
    vecs.push_back('{1, 1, 8'd3, 0, 8'd6, 0, 0, 0});  // accept 3, Q1
    vecs.push_back('{1, 0, 8'd7, 0, 8'd6, 0, 0, 0});  // Q2, input change ignored
    vecs.push_back('{1, 0, 8'd7, 0, 8'd6, 0, 0, 0});  // Q3
    vecs.push_back('{1, 0, 8'd7, 0, 8'd6, 0, 0, 0});  // Q4
    vecs.push_back('{1, 0, 8'd7, 0, 8'd6, 0, 0, 0});  // LOAD
    vecs.push_back('{1, 0, 8'd7, 0, 8'd3, 1, 1, 0});  // RESUME
    vecs.push_back('{1, 0, 8'd7, 1, 8'd3, 1, 0, 0});  // IDLE
    vecs.push_back('{0, 1, 8'd5, 0, 8'd3, 0, 0, 0});  // en=0: straight to LOAD
    vecs.push_back('{0, 0, 8'd0, 0, 8'd5, 0, 1, 0});  // RESUME
    vecs.push_back('{0, 0, 8'd0, 1, 8'd5, 0, 0, 0});  // IDLE
    vecs.push_back('{1, 1, 8'd5, 1, 8'd5, 1, 1, 0});  // same ratio: done, no drop
    vecs.push_back('{1, 0, 8'd0, 1, 8'd5, 1, 0, 0});  // idle

    rst_n = 1'b0; en = 1'b1; req_valid = 1'b0; req_ratio = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    chk_all("in_reset", 1'b1, 8'd1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_all("post_reset", 1'b1, 8'd1, 1'b1, 1'b0, 1'b0);

    foreach (vecs[i]) begin
      step(vecs[i].en, vecs[i].valid, vecs[i].ratio);
      chk_all($sformatf("vec%0d", i), vecs[i].e_ready, vecs[i].e_ratio,
              vecs[i].e_clk, vecs[i].e_upd, vecs[i].e_err);
      $display("vec %0d: en=%0b v=%0b r=%0d -> ready=%0b ratio=%0d clk_en=%0b upd=%0b err=%0b",
               i, vecs[i].en, vecs[i].valid, vecs[i].ratio, req_ready, div_ratio,
               clk_en, upd_done, err);
    end

    // Reset in the middle of a ratio-9 quiesce discards the pending ratio.
    step(1'b1, 1'b1, 8'd9);
    chk_all("r9_accept", 1'b0, 8'd5, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'd0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 1'b1, 8'd1, 1'b1, 1'b0, 1'b0);
    en = 1'b0;
    #1;
    chk("async_rst.clk_en_follows", {7'd0, clk_en}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 7; c++) begin
      step(1'b1, 1'b0, 8'd0);
    end
    chk_all("after_rst", 1'b1, 8'd1, 1'b1, 1'b0, 1'b0);
    $display("reset mid-quiesce: ratio=%0d clk_en=%0b ready=%0b", div_ratio, clk_en, req_ready);

    // Ratio-0 request.
    step(1'b1, 1'b1, 8'd0);
`ifdef RATIO_CHECK_EN
    chk_all("r0_reject", 1'b1, 8'd1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 8'd0);
    chk_all("r0_after", 1'b1, 8'd1, 1'b1, 1'b0, 1'b0);
`else
    chk_all("r0_q1", 1'b0, 8'd1, 1'b0, 1'b0, 1'b0);
    for (int c = 2; c <= 5; c++) begin
      step(1'b1, 1'b0, 8'd0);
      chk_all($sformatf("r0_c%0d", c), 1'b0, 8'd1, 1'b0, 1'b0, 1'b0);
    end
    step(1'b1, 1'b0, 8'd0);
    chk_all("r0_resume", 1'b0, 8'd0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 8'd0);
    chk_all("r0_idle", 1'b1, 8'd0, 1'b1, 1'b0, 1'b0);
`endif
    $display("ratio0 request: ratio=%0d clk_en=%0b err=%0b", div_ratio, clk_en, err);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
